// File: rtl/uart_tx_scheduler.sv
// Frame scheduler: snapshots game state on frame_tick and streams six tagged 16-bit words, high byte first, to a byte UART.
// First tx_start two cycles after frame_tick; stalls in SEND while tx_busy=1; BYTE_GAP idle cycles after each tx_done.
module uart_tx_scheduler #(
    parameter int BYTE_GAP = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [11:0] pl1_posx,
    input  logic [11:0] pl1_posy,
    input  logic [11:0] ball_posx,
    input  logic [11:0] ball_posy,
    input  logic [3:0]  pl1_score,
    input  logic [3:0]  pl2_score,
    input  logic        flag_point,
    input  logic        end_game,
    input  logic        tx_busy,
    input  logic        tx_done,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    output logic        frame_busy
);

    localparam int GW = (BYTE_GAP > 1) ? $clog2(BYTE_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST  = GW'(BYTE_GAP - 1);
    localparam logic [2:0]    LAST_WORD = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT,
        S_GAP,
        S_NEXT
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    word_idx_q, word_idx_d;
    logic          byte_sel_q, byte_sel_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          pending_q, pending_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_start_q, tx_start_d;
    logic          frame_busy_q, frame_busy_d;

    logic [11:0]   pl1_posx_q, pl1_posx_d;
    logic [11:0]   pl1_posy_q, pl1_posy_d;
    logic [11:0]   ball_posx_q, ball_posx_d;
    logic [11:0]   ball_posy_q, ball_posy_d;
    logic [3:0]    pl1_score_q, pl1_score_d;
    logic [3:0]    pl2_score_q, pl2_score_d;
    logic          flag_point_q, flag_point_d;
    logic          end_game_q, end_game_d;

    logic [15:0]   cur_word;
    logic          snap_take;
    logic          fire;
    logic [7:0]    fire_byte;

    always_comb begin
        case (word_idx_q)
            3'd0:    cur_word = {4'h1, pl1_posx_q};
            3'd1:    cur_word = {4'h2, pl1_posy_q};
            3'd2:    cur_word = {4'h5, ball_posx_q};
            3'd3:    cur_word = {4'h6, ball_posy_q};
            3'd4:    cur_word = {4'h7, 4'h0, pl1_score_q, pl2_score_q};
            3'd5:    cur_word = {4'h8, 10'b0, end_game_q, flag_point_q};
            default: cur_word = 16'h0000;
        endcase
    end

    // tx_start is a flop, so the busy check happens in the cycle that decides
    // to send (LOAD, NEXT or SEND); the pulse appears one cycle later.
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        byte_sel_d = byte_sel_q;
        gap_cnt_d  = gap_cnt_q;
        pending_d  = pending_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        snap_take  = 1'b0;
        fire       = 1'b0;
        fire_byte  = 8'h00;

        if (frame_tick && state_q != S_IDLE) begin
            pending_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (frame_tick || pending_q) begin
                    snap_take  = 1'b1;
                    word_idx_d = 3'd0;
                    byte_sel_d = 1'b0;
                    pending_d  = 1'b0;
                    state_d    = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!tx_busy) begin
                    fire      = 1'b1;
                    fire_byte = cur_word[15:8];
                    state_d   = S_WAIT;
                end else begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (!tx_busy) begin
                    fire      = 1'b1;
                    fire_byte = byte_sel_q ? cur_word[7:0] : cur_word[15:8];
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (tx_done) begin
                    gap_cnt_d = '0;
                    state_d   = (BYTE_GAP == 0) ? S_NEXT : S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = S_NEXT;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            S_NEXT: begin
                if (!byte_sel_q) begin
                    byte_sel_d = 1'b1;
                    if (!tx_busy) begin
                        fire      = 1'b1;
                        fire_byte = cur_word[7:0];
                        state_d   = S_WAIT;
                    end else begin
                        state_d = S_SEND;
                    end
                end else if (word_idx_q == LAST_WORD) begin
                    byte_sel_d = 1'b0;
                    word_idx_d = 3'd0;
                    if (pending_q || frame_tick) begin
                        snap_take = 1'b1;
                        pending_d = 1'b0;
                        state_d   = S_LOAD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    byte_sel_d = 1'b0;
                    word_idx_d = word_idx_q + 3'd1;
                    state_d    = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fire) begin
            tx_start_d = 1'b1;
            tx_data_d  = fire_byte;
        end

        pl1_posx_d   = snap_take ? pl1_posx   : pl1_posx_q;
        pl1_posy_d   = snap_take ? pl1_posy   : pl1_posy_q;
        ball_posx_d  = snap_take ? ball_posx  : ball_posx_q;
        ball_posy_d  = snap_take ? ball_posy  : ball_posy_q;
        pl1_score_d  = snap_take ? pl1_score  : pl1_score_q;
        pl2_score_d  = snap_take ? pl2_score  : pl2_score_q;
        flag_point_d = snap_take ? flag_point : flag_point_q;
        end_game_d   = snap_take ? end_game   : end_game_q;

        frame_busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            word_idx_q   <= 3'd0;
            byte_sel_q   <= 1'b0;
            gap_cnt_q    <= '0;
            pending_q    <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_start_q   <= 1'b0;
            frame_busy_q <= 1'b0;
            pl1_posx_q   <= 12'h000;
            pl1_posy_q   <= 12'h000;
            ball_posx_q  <= 12'h000;
            ball_posy_q  <= 12'h000;
            pl1_score_q  <= 4'h0;
            pl2_score_q  <= 4'h0;
            flag_point_q <= 1'b0;
            end_game_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_idx_q   <= word_idx_d;
            byte_sel_q   <= byte_sel_d;
            gap_cnt_q    <= gap_cnt_d;
            pending_q    <= pending_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            frame_busy_q <= frame_busy_d;
            pl1_posx_q   <= pl1_posx_d;
            pl1_posy_q   <= pl1_posy_d;
            ball_posx_q  <= ball_posx_d;
            ball_posy_q  <= ball_posy_d;
            pl1_score_q  <= pl1_score_d;
            pl2_score_q  <= pl2_score_d;
            flag_point_q <= flag_point_d;
            end_game_q   <= end_game_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign frame_busy = frame_busy_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: two instances (BYTE_GAP 0 and 16) share stimulus, each with a 10-cycle transmitter model.
module tb_uart_tx_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst        = 1'b1;
    logic        frame_tick = 1'b0;
    logic [11:0] px = '0, py = '0, bx = '0, by = '0;
    logic [3:0]  s1 = '0, s2 = '0;
    logic        fp = 1'b0, eg = 1'b0;
    logic        force_busy = 1'b0;

    logic [1:0]  tx_busy_w, tx_done_w, tx_start_w, frame_busy_w;
    logic [7:0]  tx_data_w [2];
    logic [1:0]  mdl_busy = 2'b00;
    logic [1:0]  mdl_done = 2'b00;
    int          mdl_cnt [2];

    assign tx_busy_w = mdl_busy | {2{force_busy}};
    assign tx_done_w = mdl_done;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        uart_tx_scheduler #(.BYTE_GAP(g * 16)) dut (
            .clk        (clk),
            .rst        (rst),
            .frame_tick (frame_tick),
            .pl1_posx   (px),
            .pl1_posy   (py),
            .ball_posx  (bx),
            .ball_posy  (by),
            .pl1_score  (s1),
            .pl2_score  (s2),
            .flag_point (fp),
            .end_game   (eg),
            .tx_busy    (tx_busy_w[g]),
            .tx_done    (tx_done_w[g]),
            .tx_data    (tx_data_w[g]),
            .tx_start   (tx_start_w[g]),
            .frame_busy (frame_busy_w[g])
        );
    end

    // Transmitter: busy for 10 cycles after tx_start, then a one-cycle done.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            mdl_done[g] <= 1'b0;
            if (tx_start_w[g]) begin
                mdl_busy[g] <= 1'b1;
                mdl_cnt[g]  <= 10;
            end else if (mdl_cnt[g] == 1) begin
                mdl_busy[g] <= 1'b0;
                mdl_done[g] <= 1'b1;
                mdl_cnt[g]  <= 0;
            end else if (mdl_cnt[g] > 1) begin
                mdl_cnt[g] <= mdl_cnt[g] - 1;
            end
        end
    end

    typedef struct packed {
        logic [11:0] px, py, bx, by;
        logic [3:0]  s1, s2;
        logic        fp, eg;
        logic [95:0] exp_bytes;
    } vec_t;

    vec_t        tbl [4];
    logic [7:0]  exp_q [$];
    int          nvec = 0, nfail = 0, cyc = 0;
    int          rd [2];
    logic [7:0]  held [2];
    logic [1:0]  have_done = 2'b00;
    logic [1:0]  busy_drop = 2'b00;
    int          done_cyc [2];

    task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s dut%0d: got 0x%0h, required 0x%0h (cycle %0d)", name, g, act, exp, cyc);
        end
    endtask

    task automatic monitor();
        for (int g = 0; g < 2; g++) begin
            if (tx_done_w[g] && frame_busy_w[g]) begin
                chk("data_hold", g, tx_data_w[g], held[g]);
                have_done[g] = 1'b1;
                done_cyc[g]  = cyc;
            end
            if (tx_start_w[g]) begin
                if (rd[g] >= exp_q.size()) begin
                    nvec++;
                    nfail++;
                    $display("FAIL extra_start dut%0d: got tx_start with data 0x%0h, required none (cycle %0d)",
                             g, tx_data_w[g], cyc);
                end else begin
                    chk("byte", g, tx_data_w[g], exp_q[rd[g]]);
                    if (have_done[g])
                        chk("spacing", g, cyc - done_cyc[g], (rd[g] % 2 == 1) ? g * 16 + 2 : g * 16 + 3);
                    rd[g]++;
                end
                held[g]      = tx_data_w[g];
                have_done[g] = 1'b0;
            end
            if (rd[g] < exp_q.size() && !frame_busy_w[g]) busy_drop[g] = 1'b1;
            if (!frame_busy_w[g]) have_done[g] = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
        monitor();
    endtask

    task automatic apply(input vec_t v);
        px = v.px; py = v.py; bx = v.bx; by = v.by;
        s1 = v.s1; s2 = v.s2; fp = v.fp; eg = v.eg;
    endtask

    task automatic push(input int i);
        logic [95:0] e;
        e = tbl[i].exp_bytes;
        for (int b = 0; b < 12; b++) exp_q.push_back(e[95 - 8 * b -: 8]);
    endtask

    task automatic flush();
        for (int g = 0; g < 2; g++) rd[g] = exp_q.size();
    endtask

    // Tick in this cycle; frame_busy must show at T+1 and tx_start at T+2.
    task automatic start_frame(input int i);
        apply(tbl[i]);
        push(i);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        for (int g = 0; g < 2; g++) chk("busy_t1", g, frame_busy_w[g], 1);
        step();
        for (int g = 0; g < 2; g++) chk("start_t2", g, tx_start_w[g], 1);
    endtask

    task automatic wait_frames(input int budget);
        int n = 0;
        while ((frame_busy_w != 2'b00 || rd[0] != exp_q.size() || rd[1] != exp_q.size()) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            nvec++;
            nfail++;
            $display("FAIL timeout: frame not finished after %0d cycles", budget);
        end
        for (int g = 0; g < 2; g++) begin
            chk("byte_count", g, rd[g], exp_q.size());
            chk("busy_end", g, frame_busy_w[g], 0);
            chk("busy_cont", g, busy_drop[g], 0);
        end
        busy_drop = 2'b00;
        repeat (5) step();
    endtask

    initial begin
        logic [7:0] d0 [2];
        logic [1:0] stall_start, stall_data;
        int         n;

        tbl[0] = '{12'h123, 12'h0AB, 12'hFFF, 12'h000, 4'd3, 4'd7, 1'b1, 1'b0, 96'h1123_20AB_5FFF_6000_7037_8001};
        tbl[1] = '{12'h456, 12'h0AB, 12'hFFF, 12'h000, 4'd3, 4'd7, 1'b1, 1'b0, 96'h1456_20AB_5FFF_6000_7037_8001};
        tbl[2] = '{12'h000, 12'hFFF, 12'hABC, 12'h5A5, 4'hF, 4'h0, 1'b0, 1'b1, 96'h1000_2FFF_5ABC_65A5_70F0_8002};
        tbl[3] = '{12'h7E1, 12'h81E, 12'h001, 12'h800, 4'h9, 4'hA, 1'b1, 1'b1, 96'h17E1_281E_5001_6800_709A_8003};
        rd[0] = 0;
        rd[1] = 0;

        repeat (3) step();
        rst = 1'b0;
        step();
        for (int g = 0; g < 2; g++) begin
            chk("rst_data", g, tx_data_w[g], 8'h00);
            chk("rst_start", g, tx_start_w[g], 0);
            chk("rst_busy", g, frame_busy_w[g], 0);
        end

        // Table frames; inputs move to the next entry right after the first
        // tx_start, so vector 0's frame must still carry 0x123 and vector 1's 0x456.
        for (int i = 0; i < 4; i++) begin
            start_frame(i);
            apply(tbl[(i + 1) % 4]);
            wait_frames(2000);
        end

        // Back-pressure from frame start: 50 cycles stalled in SEND.
        force_busy = 1'b1;
        apply(tbl[1]);
        push(1);
        frame_tick = 1'b1;
        step();
        frame_tick  = 1'b0;
        stall_start = 2'b00;
        stall_data  = 2'b00;
        for (int g = 0; g < 2; g++) d0[g] = tx_data_w[g];
        for (int k = 0; k < 50; k++) begin
            step();
            for (int g = 0; g < 2; g++) begin
                if (tx_start_w[g]) stall_start[g] = 1'b1;
                if (tx_data_w[g] !== d0[g]) stall_data[g] = 1'b1;
            end
        end
        for (int g = 0; g < 2; g++) begin
            chk("stall_start", g, stall_start[g], 0);
            chk("stall_data", g, stall_data[g], 0);
        end
        force_busy = 1'b0;
        step();
        for (int g = 0; g < 2; g++) chk("release_start", g, tx_start_w[g], 1);
        wait_frames(2000);

        // Three ticks mid-frame: exactly one back-to-back extra frame.
        start_frame(2);
        for (int k = 1; k <= 70; k++) begin
            step();
            if (k == 20) begin
                apply(tbl[3]);
                push(3);
            end
            frame_tick = (k == 20 || k == 40 || k == 60);
        end
        frame_tick = 1'b0;
        wait_frames(4000);

        // Reset after byte 5, then a clean frame from the first byte.
        start_frame(0);
        n = 0;
        while (rd[0] < exp_q.size() - 7 && n < 500) begin
            step();
            n++;
        end
        if (n >= 500) begin
            nvec++;
            nfail++;
            $display("FAIL timeout: byte 5 never sent");
        end
        rst = 1'b1;
        flush();
        step();
        rst = 1'b0;
        for (int g = 0; g < 2; g++) begin
            chk("abort_data", g, tx_data_w[g], 8'h00);
            chk("abort_start", g, tx_start_w[g], 0);
            chk("abort_busy", g, frame_busy_w[g], 0);
        end
        repeat (40) step();
        start_frame(0);
        wait_frames(2000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Sequences the local game state onto the inter-board UART link. On each frame tick it snapshots player-1 position, ball position, scores and game flags. It packs them into six tagged 16-bit words (tag in [15:12], payload in [11:0]) and drives a byte-wide UART transmitter through a start/done handshake, high byte first. It is the transmit-side counterpart of the tagged-word demultiplexer on the peer board.

## Interface
- BYTE_GAP, 16, idle clock cycles inserted after every tx_done before the next tx_start (0 allowed)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse requesting transmission of a new frame
- pl1_posx  in  12  player-1 x position
- pl1_posy  in  12  player-1 y position
- ball_posx  in  12  ball x position
- ball_posy  in  12  ball y position
- pl1_score  in  4  player-1 score
- pl2_score  in  4  player-2 score
- flag_point  in  1  point-scored flag
- end_game  in  1  game-over flag
- tx_busy  in  1  transmitter busy; tx_start must not assert while high
- tx_done  in  1  one-cycle pulse, byte fully shifted out
- tx_data  out  8  byte to transmit; registered; stable from tx_start until tx_done
- tx_start  out  1  one-cycle pulse, registered
- frame_busy  out  1  high from frame start until the last byte's gap has expired

## Operation
- Word order and tags, fixed:
  - 0: tag 1, pl1_posx
  - 1: tag 2, pl1_posy
  - 2: tag 5, ball_posx
  - 3: tag 6, ball_posy
  - 4: tag 7, {4'b0, pl1_score, pl2_score}
  - 5: tag 8, {10'b0, end_game, flag_point}
- Tags 3 and 4 are reserved for the peer's player-2 position and are never emitted.
- Snapshot: all inputs are registered in the same cycle the frame starts. Input changes during a frame do not affect that frame.
- Each word is sent as two bytes: word[15:8], then word[7:0]. A frame is 12 bytes.
- FSM states:
  - IDLE: frame_busy=0; waits for frame_tick or pending.
  - LOAD: selects the word at word_idx.
  - SEND: waits for tx_busy=0, then pulses tx_start with tx_data.
  - WAIT: waits for tx_done.
  - GAP: counts BYTE_GAP cycles.
  - NEXT: advances byte_sel/word_idx.
- Transitions:
  - IDLE->LOAD on start (snapshot taken, word_idx=0, byte_sel=0).
  - LOAD->SEND.
  - SEND->WAIT when tx_start issued.
  - WAIT->GAP on tx_done.
  - GAP->NEXT when the counter reaches BYTE_GAP. With BYTE_GAP=0 this is immediate.
  - NEXT->SEND for the low byte; NEXT->LOAD for the next word.
  - After word 5's low byte: NEXT->IDLE, or NEXT->LOAD with a fresh snapshot if pending=1 (pending cleared).
- Pending: a frame_tick arriving while frame_busy=1 sets a one-deep pending flag. Further ticks while pending=1 are dropped.
- frame_tick in the same cycle as the frame end counts as pending.
- tx_done outside WAIT is ignored.
- Counters: word_idx 3 bits, range 0..5, never wraps past 5. Gap counter wide enough for BYTE_GAP.

## Timing
- Reset values: tx_data=0, tx_start=0, frame_busy=0, state IDLE, pending=0, word_idx=0, byte_sel=0, gap counter=0.
- Reset mid-frame aborts the frame in the next cycle with no further tx_start. A byte already in the transmitter is not retracted.
- Cycle T: frame_tick=1 in IDLE. Snapshot and frame_busy=1 are visible at T+1 (LOAD). tx_start is high in cycle T+2 if tx_busy=0.
- SEND stalls indefinitely while tx_busy=1. tx_start asserts in the first SEND cycle with tx_busy=0, for exactly one cycle.
- tx_data is updated no later than the cycle tx_start asserts and is held until tx_done.
- Minimum spacing is tx_done to next tx_start = BYTE_GAP+2 cycles (GAP exit, NEXT, then SEND; +1 LOAD at word boundaries).
- frame_busy falls in the cycle after the last NEXT unless a pending frame restarts. On restart it stays high continuously.

## Test plan
- Basic frame, BYTE_GAP=0, transmitter model with 10-cycle busy: pl1_posx=0x123, pl1_posy=0x0AB, ball_posx=0xFFF, ball_posy=0x000, scores 3/7, flag_point=1, end_game=0. Required byte stream: 11 23 20 AB 5F FF 60 00 70 37 80 01. Exactly 12 tx_start pulses, then frame_busy=0.
- Snapshot isolation: change pl1_posx to 0x456 after the first tx_start. Required: that frame still sends 11 23. The next frame sends 14 56.
- Back-pressure: hold tx_busy=1 for 50 cycles while in SEND. Required: tx_start stays 0 and tx_data stays stable. tx_start pulses exactly once on the first cycle with tx_busy=0.
- Pending: send three frame_ticks mid-frame. Required: exactly one extra frame, 24 bytes total, with frame_busy never dropping between frames.
- Gap: BYTE_GAP=16. Required: tx_done to next tx_start is 18 cycles within a word and 19 cycles across a word boundary.
- Reset: assert rst after byte 5. Required: all outputs return to reset values next cycle, and no tx_start occurs until a new frame_tick. The new frame starts from byte 11.
